// File: rtl/prbs7_frame_gen.sv
// PRBS7 (x^7+x^6+1) 64-bit-per-cycle pattern source with forward bit map,
// programmable bit-slip and counted single-bit error-burst injection.
module prbs7_frame_gen #(
    parameter logic [6:0] SEED = 7'h7F
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        bypass,
    input  logic [5:0]  slip_addr,
    input  logic        inj_req,
    input  logic [5:0]  inj_pos,
    input  logic [3:0]  inj_len,
    output logic        inj_busy,
    output logic        dout_valid,
    output logic [63:0] dout,
    output logic [31:0] word_count,
    output logic [15:0] inj_total
);

    localparam logic [6:0] SEED_EFF = (SEED == 7'h00) ? 7'h7F : SEED;

    typedef enum logic [1:0] {IDLE, RUN, INJ} state_t;

    state_t      state;
    logic [6:0]  lfsr;
    logic [5:0]  pos_lat;
    logic [3:0]  remain;
    logic [70:0] step;

    logic [63:0] word_p1;
    logic        vld_p1;
    logic        inj_p1;
    logic [5:0]  pos_p1;
    logic [63:0] mapped_p1;

    logic [63:0] word_p2;
    logic        vld_p2;
    logic        inj_p2;

    // lfsr[k] holds b[n-7+k]; each output bit is the freshly generated b[n].
    function automatic logic [70:0] prbs_step64(input logic [6:0] s_in);
        logic [6:0]  s;
        logic [63:0] w;
        logic        nb;
        s = s_in;
        w = '0;
        for (int i = 0; i < 64; i++) begin
            nb   = s[0] ^ s[1];
            w[i] = nb;
            s    = {nb, s[6:1]};
        end
        return {s, w};
    endfunction

    function automatic logic [63:0] fwd_map(input logic [63:0] w, input logic byp);
        logic [63:0] rv;
        for (int i = 0; i < 64; i++) begin
            rv[i] = w[63-i];
        end
        return byp ? w : rv;
    endfunction

    function automatic logic [63:0] slip_select(input logic [127:0] win, input logic [5:0] sh);
        logic [127:0] t;
        t = win >> sh;
        return t[63:0];
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign step = prbs_step64(lfsr);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            lfsr     <= SEED_EFF;
            pos_lat  <= '0;
            remain   <= '0;
            inj_busy <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    lfsr     <= SEED_EFF;
                    inj_busy <= 1'b0;
                    if (enable) state <= RUN;
                end
                RUN: begin
                    if (!enable) begin
                        state <= IDLE;
                        lfsr  <= SEED_EFF;
                    end else begin
                        lfsr <= step[70:64];
                        if (inj_req) begin
                            pos_lat  <= inj_pos;
                            remain   <= (inj_len == 4'd0) ? 4'd1 : inj_len;
                            state    <= INJ;
                            inj_busy <= 1'b1;
                        end
                    end
                end
                INJ: begin
                    if (!enable) begin
                        state    <= IDLE;
                        lfsr     <= SEED_EFF;
                        inj_busy <= 1'b0;
                    end else begin
                        lfsr <= step[70:64];
                        if (remain == 4'd1) begin
                            state    <= RUN;
                            inj_busy <= 1'b0;
                        end else begin
                            remain <= remain - 4'd1;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    inj_busy <= 1'b0;
                end
            endcase
        end
    end

    // S1: raw PRBS word, tagged with the burst state that produced it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_p1 <= '0;
            vld_p1  <= 1'b0;
            inj_p1  <= 1'b0;
            pos_p1  <= '0;
        end else if (state == RUN || state == INJ) begin
            word_p1 <= step[63:0];
            vld_p1  <= 1'b1;
            inj_p1  <= (state == INJ);
            pos_p1  <= pos_lat;
        end else begin
            word_p1 <= '0;
            vld_p1  <= 1'b0;
            inj_p1  <= 1'b0;
        end
    end

    // The mapped S1 word is also the "cur" half of the slip window.
    assign mapped_p1 = vld_p1 ? fwd_map(word_p1 ^ (inj_p1 ? (64'd1 << pos_p1) : 64'd0), bypass)
                              : 64'd0;

    // S2: mask XOR and forward map
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_p2 <= '0;
            vld_p2  <= 1'b0;
            inj_p2  <= 1'b0;
        end else begin
            word_p2 <= mapped_p1;
            vld_p2  <= vld_p1;
            inj_p2  <= vld_p1 & inj_p1;
        end
    end

    // S3: slip window {cur, prev}, output word and counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            word_count <= '0;
            inj_total  <= '0;
        end else begin
            dout       <= vld_p2 ? slip_select({mapped_p1, word_p2}, slip_addr) : 64'd0;
            dout_valid <= vld_p2;
            word_count <= word_count + {31'd0, vld_p2};
            if (vld_p2 && inj_p2) inj_total <= sat_inc16(inj_total);
        end
    end

endmodule

// File: tb/tb_prbs7_frame_gen.sv
// Bench for prbs7_frame_gen: table-driven bursts, clean/map streams, slip sweep,
// random runs and corner cases, all checked against a bit-sequence reference.
module tb_prbs7_frame_gen;

    localparam int BIG = 1 << 30;

    logic        clk = 1'b0;
    logic        reset, enable, bypass, inj_req;
    logic [5:0]  slip_addr, inj_pos;
    logic [3:0]  inj_len;
    logic        inj_busy, dout_valid, inj_busy0, dout_valid0;
    logic [63:0] dout, dout0;
    logic [31:0] word_count, word_count0;
    logic [15:0] inj_total, inj_total0;

    prbs7_frame_gen #(.SEED(7'h7F)) dut (
        .clk(clk), .reset(reset), .enable(enable), .bypass(bypass),
        .slip_addr(slip_addr), .inj_req(inj_req), .inj_pos(inj_pos), .inj_len(inj_len),
        .inj_busy(inj_busy), .dout_valid(dout_valid), .dout(dout),
        .word_count(word_count), .inj_total(inj_total)
    );

    prbs7_frame_gen #(.SEED(7'h00)) dut0 (
        .clk(clk), .reset(reset), .enable(enable), .bypass(bypass),
        .slip_addr(slip_addr), .inj_req(inj_req), .inj_pos(inj_pos), .inj_len(inj_len),
        .inj_busy(inj_busy0), .dout_valid(dout_valid0), .dout(dout0),
        .word_count(word_count0), .inj_total(inj_total0)
    );

    always #5 clk = ~clk;

    int          n_checks, n_fail;
    int          r, d;
    bit          started;
    logic [31:0] exp_wc;
    logic [15:0] exp_it;
    logic        gen [0:126];
    int          b_r0[$];
    int          b_len[$];
    int          b_pos[$];

    typedef struct {
        logic       byp;
        logic [5:0] slip;
        logic [5:0] pos;
        logic [3:0] len;
        int         req_at;
        int         req2_at;
        int         nwords;
        int         exp_corrupt;
        int         exp_busy;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, expv, r);
        end
    endtask

    function automatic logic [63:0] prbs_word(input int k);
        logic [63:0] w;
        for (int i = 0; i < 64; i++) w[i] = gen[(64 * k + i) % 127];
        return w;
    endfunction

    function automatic int corrupt_pos(input int k);
        for (int j = 0; j < b_r0.size(); j++)
            if (k >= b_r0[j] && k <= b_r0[j] + b_len[j] - 1 && k <= d - 1) return b_pos[j];
        return -1;
    endfunction

    function automatic logic [63:0] mword(input int k);
        logic [63:0] w;
        int          p;
        w = prbs_word(k);
        p = corrupt_pos(k);
        if (p >= 0) w[p] = ~w[p];
        return bypass ? w : {<<{w}};
    endfunction

    task automatic check_cycle();
        int           k;
        bit           vld, busy;
        logic [63:0]  m0, m1, ed;
        logic [127:0] cat;
        k   = r - 3;
        vld = started && k >= 0 && k <= d - 1;
        ed  = '0;
        if (vld) begin
            m0  = mword(k);
            m1  = (k + 1 <= d - 1) ? mword(k + 1) : 64'd0;
            cat = {m1, m0} >> slip_addr;
            ed  = cat[63:0];
            exp_wc = exp_wc + 32'd1;
            if (corrupt_pos(k) >= 0) exp_it = (exp_it == 16'hFFFF) ? exp_it : exp_it + 16'd1;
        end
        busy = 1'b0;
        if (started)
            for (int j = 0; j < b_r0.size(); j++)
                if (r >= b_r0[j] && r <= b_r0[j] + b_len[j] - 1 && r < d) busy = 1'b1;
        chk("dout_valid", 64'(dout_valid), 64'(vld));
        chk("dout", dout, ed);
        chk("inj_busy", 64'(inj_busy), 64'(busy));
        chk("word_count", 64'(word_count), 64'(exp_wc));
        chk("inj_total", 64'(inj_total), 64'(exp_it));
        chk("seed0_valid", 64'(dout_valid0), 64'(vld));
        chk("seed0_dout", dout0, ed);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        r++;
        check_cycle();
    endtask

    task automatic drain(input int n);
        repeat (n) tick();
    endtask

    task automatic start_run();
        b_r0.delete(); b_len.delete(); b_pos.delete();
        started = 1'b1;
        d       = BIG;
        r       = -1;
        enable  = 1'b1;
        tick();
    endtask

    task automatic stop_run();
        enable = 1'b0;
        d      = r + 1;
        tick();
    endtask

    task automatic req(input logic [5:0] pos, input logic [3:0] len);
        int r0, le;
        bit acc;
        r0  = r + 1;
        le  = (len == 4'd0) ? 1 : int'(len);
        acc = started && r0 >= 1 && r0 <= d - 1;
        if (b_r0.size() > 0 && r0 < b_r0[$] + b_len[$] + 1) acc = 1'b0;
        if (acc) begin
            b_r0.push_back(r0); b_len.push_back(le); b_pos.push_back(int'(pos));
        end
        inj_pos = pos;
        inj_len = len;
        inj_req = 1'b1;
        tick();
        inj_req = 1'b0;
    endtask

    initial begin
        logic        b [0:133];
        logic [15:0] it_before;
        int          busy_cnt, len_run;

        reset = 1'b0; enable = 1'b0; bypass = 1'b1; slip_addr = '0;
        inj_req = 1'b0; inj_pos = '0; inj_len = '0;
        n_checks = 0; n_fail = 0; r = 0; d = BIG; started = 1'b0;
        exp_wc = '0; exp_it = '0;

        for (int n = 0; n < 7; n++) b[n] = 1'b1;
        for (int n = 7; n < 134; n++) b[n] = b[n-6] ^ b[n-7];
        for (int j = 0; j < 127; j++) gen[j] = b[7 + j];

        vecs[0] = '{1'b1, 6'd0,  6'd5,  4'd3,  5, 6, 20, 3, 3};
        vecs[1] = '{1'b0, 6'd0,  6'd5,  4'd3,  5, 8, 20, 3, 3};
        vecs[2] = '{1'b1, 6'd1,  6'd0,  4'd0,  3, 0, 15, 1, 1};
        vecs[3] = '{1'b0, 6'd31, 6'd63, 4'd15, 4, 0, 30, 15, 15};
        vecs[4] = '{1'b1, 6'd63, 6'd32, 4'd1,  2, 4, 15, 2, 2};
        vecs[5] = '{1'b0, 6'd0,  6'd9,  4'd3,  1, 5, 15, 6, 6};

        #1;
        chk("reset dout", dout, 64'd0);
        chk("reset dout_valid", 64'(dout_valid), 64'd0);
        chk("reset inj_busy", 64'(inj_busy), 64'd0);
        chk("reset word_count", 64'(word_count), 64'd0);
        chk("reset inj_total", 64'(inj_total), 64'd0);
        tick(); tick();
        @(negedge clk);
        reset = 1'b1;
        drain(3);

        // Clean stream, identity map
        bypass = 1'b1; slip_addr = '0;
        start_run();
        while (r < 10002) begin
            tick();
            if (r == 2) chk("latency pre", 64'(dout_valid), 64'd0);
            if (r == 3) chk("latency first", 64'(dout_valid), 64'd1);
        end
        chk("clean word_count", 64'(word_count), 64'd10000);
        chk("clean inj_total", 64'(inj_total), 64'd0);
        stop_run(); drain(4);

        // Clean stream, reversed map
        bypass = 1'b0;
        start_run();
        while (r < 10002) tick();
        stop_run(); drain(4);

        // Burst table
        foreach (vecs[i]) begin
            bypass = vecs[i].byp; slip_addr = vecs[i].slip;
            it_before = exp_it;
            busy_cnt = 0;
            start_run();
            while (r < vecs[i].nwords + 3) begin
                if (r + 1 == vecs[i].req_at || r + 1 == vecs[i].req2_at)
                    req(vecs[i].pos, vecs[i].len);
                else
                    tick();
                if (inj_busy) busy_cnt++;
            end
            stop_run(); drain(4);
            chk("vec busy cycles", 64'(busy_cnt), 64'(vecs[i].exp_busy));
            chk("vec corrupted words", 64'(inj_total - it_before), 64'(vecs[i].exp_corrupt));
        end

        // Slip sweep
        bypass = 1'b0; slip_addr = 6'd0;
        start_run();
        drain(20); slip_addr = 6'd1;
        drain(20); slip_addr = 6'd31;
        drain(20); slip_addr = 6'd63;
        drain(20);
        stop_run(); drain(4);

        // Randomized runs
        for (int s = 0; s < 8; s++) begin
            bypass = 1'($urandom_range(1, 0));
            slip_addr = 6'($urandom_range(63, 0));
            len_run = int'($urandom_range(120, 40));
            start_run();
            while (r < len_run) begin
                if ($urandom_range(7, 0) == 0)
                    req(6'($urandom_range(63, 0)), 4'($urandom_range(15, 0)));
                else
                    tick();
                if ($urandom_range(9, 0) == 0) slip_addr = 6'($urandom_range(63, 0));
            end
            stop_run(); drain(4);
        end

        // enable dropped mid-burst: words 2 and 3 are the only corrupted ones
        bypass = 1'b1; slip_addr = 6'd7;
        it_before = exp_it;
        start_run();
        tick();
        req(6'd12, 4'd10);
        tick();
        stop_run();
        chk("abandon busy", 64'(inj_busy), 64'd0);
        drain(5);
        chk("abandon total", 64'(inj_total), 64'(it_before + 16'd2));

        // word_count wrap
        bypass = 1'b0; slip_addr = 6'd0;
        start_run();
        drain(5);
        force dut.word_count = 32'hFFFF_FFFF;
        #1;
        release dut.word_count;
        exp_wc = 32'hFFFF_FFFF;
        tick();
        chk("word_count wrap", 64'(word_count), 64'd0);
        drain(2);

        // inj_total saturation
        force dut.inj_total = 16'hFFFE;
        #1;
        release dut.inj_total;
        exp_it = 16'hFFFE;
        req(6'd3, 4'd3);
        drain(8);
        chk("inj_total saturate", 64'(inj_total), 64'h0000_0000_0000_FFFF);
        stop_run(); drain(4);

        // Asynchronous reset mid-burst, then restart from word 0
        bypass = 1'b0; slip_addr = 6'd5;
        start_run();
        tick();
        req(6'd10, 4'd10);
        drain(3);
        #2 reset = 1'b0;
        #1;
        chk("async dout", dout, 64'd0);
        chk("async dout_valid", 64'(dout_valid), 64'd0);
        chk("async inj_busy", 64'(inj_busy), 64'd0);
        chk("async word_count", 64'(word_count), 64'd0);
        chk("async inj_total", 64'(inj_total), 64'd0);
        chk("async seed0 dout", dout0, 64'd0);
        started = 1'b0; enable = 1'b0; exp_wc = '0; exp_it = '0;
        b_r0.delete(); b_len.delete(); b_pos.delete();
        tick(); tick();
        @(negedge clk);
        reset = 1'b1;
        tick();
        start_run();
        while (r < 15) tick();
        stop_run(); drain(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/prbs7_frame_gen.md
# prbs7_frame_gen

- Transmit-side PRBS7 pattern source for the 64-bit SERDES link test path; drives the parallel word that the receive-side aligner and PRBS7 checker lock onto.
- Produces a continuous 64-bit-per-cycle PRBS7 stream and applies the forward bit map, the counterpart of the receiver's reverse map.
- Applies a programmable bit-slip so the receiver's alignment search can be exercised at every offset.
- Injects controlled single-bit error bursts and counts them, so the receiver's error counters can be checked against a known total.

## Interface

Parameters
- SEED, 7'h7F, initial PRBS7 state loaded on reset and on each enable rising edge; 7'h00 is replaced by 7'h7F.

Ports
- clk, input, 1: single clock; all logic on posedge.
- reset, input, 1: asynchronous, active-low. Clears all state immediately; release is synchronous to clk.
- enable, input, 1: 1 = stream running; 0 = idle, output forced to zero.
- bypass, input, 1: 1 = skip the forward map, 0 = apply it. Sampled every cycle.
- slip_addr, input, 6: bit offset in the range 0..63 applied to the output stream.
- inj_req, input, 1: one-cycle request to start an error burst.
- inj_pos, input, 6: index of the bit flipped in each corrupted word.
- inj_len, input, 4: number of consecutive words to corrupt; 0 is treated as 1.
- inj_busy, output, 1: burst in progress.
- dout_valid, output, 1: dout carries stream data.
- dout, output, 64: transmitted word.
- word_count, output, 32: valid words emitted; wraps at 2^32.
- inj_total, output, 16: corrupted words emitted; saturates at 16'hFFFF.

## Operation

- **PRBS core:** polynomial x^7+x^6+1, serial recurrence b[n] = b[n-6] ^ b[n-7].
  - Each cycle advances 64 steps.
  - Word bit 0 is the earliest bit in time.
  - Bit 63 of word k is followed by bit 0 of word k+1.
- **Forward map:** map(w)[i] = w[63-i] (full bit reversal). When bypass=1, map is the identity.
- **Error injection:** mask = 64'b1 << inj_pos, XORed into the PRBS word before the map is applied.
- **Slip stage:**
  - Holds the current mapped word cur and the previous one prev.
  - Forms the 128-bit value {cur, prev}.
  - dout = bits [slip_addr+63 : slip_addr] of that value.
  - slip_addr = 0 gives dout = prev.
- **State machine:**
  - IDLE: core holds SEED. Exits to RUN on enable=1.
  - RUN: streaming. inj_req=1 latches inj_pos and max(inj_len,1), then moves to INJ.
  - INJ: each cycle corrupts one word and decrements the remaining-words counter. Returns to RUN after the last corrupted word.
  - From RUN or INJ, enable=0 goes to IDLE. An unfinished burst is abandoned: inj_busy drops and inj_total keeps its current value.
- **Handshake:**
  - inj_busy=1 exactly while in INJ.
  - inj_req while inj_busy=1, or while in IDLE, is ignored; no queuing.
  - inj_req in the cycle a burst ends (last INJ cycle) is also ignored.
- **Counters:**
  - word_count increments on every dout_valid cycle.
  - inj_total increments once per corrupted word as it appears on dout.
- **Reset values:** dout=0, dout_valid=0, inj_busy=0, word_count=0, inj_total=0, state=IDLE, PRBS state=SEED, slip buffer=0.

## Timing

- **Pipeline, three registered stages:**
  - S1: PRBS word.
  - S2: mask XOR and map.
  - S3: slip, driving dout.
- **Enable on:** enable rising at edge t puts word 0 (first 64 bits from SEED) on dout at edge t+3 with dout_valid=1.
- **Enable off:** enable falling at edge t gives dout_valid=0 and dout=0 from edge t+3. Words already in flight are flushed, not emitted.
- **Re-enable:** the stream restarts from SEED, word 0.
- **Injection:** inj_req at edge t (in RUN) makes the word generated at S1 edge t+1 the first corrupted word; it reaches dout at t+3. inj_busy is high over edges t+1 .. t+len.
- **Slip change:** a new slip_addr takes effect on the next S3 edge. One boundary word may be discontinuous. No other state is disturbed.
- **Mid-operation reset:** assertion clears outputs asynchronously, within the same cycle. After release the block behaves as after power-up.

## Test plan

- **Clean stream.** Stimulus: reset released, enable=1, bypass=1, slip_addr=0. Required: dout_valid rises 3 cycles after enable; 10,000 words match a software PRBS7 reference seeded with 7'h7F; inj_total=0; word_count=10,000.
- **Map.** Stimulus: bypass=0, otherwise as above. Required: every dout is the bit reversal of the reference word. Looping into the receive path gives errorCounter=0 and aligned=1.
- **Slip sweep.** Stimulus: slip_addr set to 0, 1, 31, 63 in turn. Required: dout equals {cur, prev} >> slip_addr. Looped back, the receiver locks with alignAddr equal to the offset that compensates the slip.
- **Burst.** Stimulus: inj_pos=5, inj_len=3, inj_req for one cycle. Required: exactly 3 consecutive words differ from the reference, only in bit 5; inj_busy is high for 3 cycles; inj_total=3. A second inj_req during the burst is ignored.
- **Boundaries.**
  - inj_len=0 corrupts 1 word.
  - Driving inj_total past 16'hFFFF holds it at FFFF.
  - Forcing word_count to 32'hFFFFFFFF wraps it to 0.
  - SEED=0 behaves identically to SEED=7'h7F.
- **Reset and enable mid-burst.** Stimulus: reset low during INJ. Required: all outputs 0 in the same cycle, with no clock edge needed. After release and enable, the stream restarts at word 0. enable=0 mid-burst ends the burst and inj_total keeps its value.
